// File: rtl/sdram_cache_arbiter.sv
// rtl/sdram_cache_arbiter.sv - round-robin arbiter sharing one burst SDRAM port between two cache clients
module sdram_cache_arbiter #(
    parameter int burstlen = 8,
    parameter int cntbits  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_req,
    input  logic        c0_rw,
    input  logic [31:0] c0_addr,
    input  logic [15:0] c0_wdata,
    output logic        c0_fill,
    output logic        c0_ack,
    input  logic        c1_req,
    input  logic        c1_rw,
    input  logic [31:0] c1_addr,
    input  logic [15:0] c1_wdata,
    output logic        c1_fill,
    output logic        c1_ack,
    output logic [15:0] data_to_clients,
    output logic        mem_req,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_fill,
    input  logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RDWAIT, BURST, WRWAIT} state_t;

    localparam logic [cntbits-1:0] cnt_last = cntbits'(burstlen - 1);
    localparam logic [cntbits-1:0] cnt_one  = cntbits'(1);
    localparam logic single_word = (burstlen == 1);

    state_t             state;
    state_t             state_next;
    logic [cntbits-1:0] cnt;
    logic               last;
    logic               any_req;
    logic               pick;
    logic               pick_rw;

    // pick: 0 selects client 0; on contention the client that did not win last time goes
    always_comb begin
        any_req = c0_req | c1_req;
        if (c0_req && c1_req) begin
            pick = ~last;
        end else begin
            pick = c1_req;
        end
        pick_rw = pick ? c1_rw : c0_rw;
    end

    always_comb begin
        state_next = state;
        c0_fill    = 1'b0;
        c1_fill    = 1'b0;
        c0_ack     = 1'b0;
        c1_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = pick_rw ? RDWAIT : WRWAIT;
                end
            end
            RDWAIT: begin
                if (mem_fill) begin
                    c0_fill    = grant[0];
                    c1_fill    = grant[1];
                    state_next = single_word ? IDLE : BURST;
                end
            end
            BURST: begin
                if (cnt == cnt_last) begin
                    state_next = IDLE;
                end
            end
            WRWAIT: begin
                if (mem_ack) begin
                    c0_ack     = grant[0];
                    c1_ack     = grant[1];
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= 2'b00;
            last     <= 1'b1;
            mem_req  <= 1'b0;
            mem_rw   <= 1'b1;
            mem_addr <= 32'h0;
            cnt      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= pick ? 2'b10 : 2'b01;
                        last     <= pick;
                        mem_addr <= pick ? c1_addr : c0_addr;
                        mem_rw   <= pick_rw;
                        mem_req  <= 1'b1;
                    end
                end
                RDWAIT: begin
                    if (mem_fill) begin
                        mem_req <= 1'b0;
                        cnt     <= cnt_one;
                        if (single_word) begin
                            grant <= 2'b00;
                        end
                    end
                end
                BURST: begin
                    cnt <= cnt + cnt_one;
                    if (cnt == cnt_last) begin
                        grant <= 2'b00;
                    end
                end
                WRWAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        grant   <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

    // Burst data is never stalled, so the controller's bus is simply fanned out
    assign data_to_clients = mem_data;
    assign mem_wdata       = grant[1] ? c1_wdata : (grant[0] ? c0_wdata : 16'h0);
    assign busy            = (state != IDLE);

endmodule
